// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt controller.
package intr_pkg;

   localparam int unsigned NUM_IRQ_DEF     = 8;
   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned INT_ID_W        = $clog2(NUM_IRQ_DEF);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } intr_state_e;

endpackage

// File: rtl/intr_sync.sv
// One interrupt source: multi-flop synchronizer followed by rising-edge detect.
// With INTR_LEVEL_EN defined the edge flop is dropped and the synchronized level is passed on.
module intr_sync
   import intr_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq_i,
   output logic event_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

`ifdef INTR_LEVEL_EN
   assign event_c = sync_q[SYNC_STAGES-1];
`else
   logic edge_q;
   logic edge_d;

   always_comb begin
      edge_d = sync_q[SYNC_STAGES-1];
   end

   // Edge flop resets low so a line held high through reset counts as one new edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_q <= 1'b0;
      end else begin
         edge_q <= edge_d;
      end
   end

   assign event_c = sync_q[SYNC_STAGES-1] & ~edge_q;
`endif

endmodule

// File: rtl/intr_ctrl.sv
// Fixed-priority interrupt controller: per-source sync, pending latch, enable mask, CPU handshake FSM.
// Define INTR_LEVEL_EN for level-sensitive sources (pending mirrors the synchronized line).
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int unsigned NUM_IRQ     = NUM_IRQ_DEF,
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   localparam int unsigned ID_W       = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               mie,
   input  logic               int_taken,
   input  logic               mret_exec,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_wd,
   output logic               intr,
   output logic [ID_W-1:0]    int_id,
   output logic [NUM_IRQ-1:0] pending,
   output logic [NUM_IRQ-1:0] mask
);

   intr_state_e        state_q, state_d;
   logic               intr_q, intr_d;
   logic [ID_W-1:0]    int_id_q, int_id_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] event_c;
   logic [NUM_IRQ-1:0] elig_c;
   logic [ID_W-1:0]    prio_id_c;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
      intr_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk     (clk),
         .rst_n   (rst_n),
         .irq_i   (irq[g]),
         .event_c (event_c[g])
      );
   end

`ifdef INTR_LEVEL_EN
   assign pending = event_c;
`else
   logic [NUM_IRQ-1:0] pending_q, pending_d;

   // Acceptance clears the granted bit; a same-cycle new edge wins and keeps it set.
   always_comb begin
      pending_d = pending_q;
      if (state_q == ST_REQ && int_taken) begin
         pending_d[int_id_q] = 1'b0;
      end
      pending_d = pending_d | event_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;
`endif

   always_comb begin
      mask_d = mask_we ? mask_wd : mask_q;
   end

   // Lowest eligible index has highest priority.
   always_comb begin
      elig_c    = pending & mask_q;
      prio_id_c = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (elig_c[i]) begin
            prio_id_c = ID_W'(i);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      intr_d   = intr_q;
      int_id_d = int_id_q;
      case (state_q)
         ST_IDLE: begin
            intr_d = 1'b0;
            if (mie && (|elig_c)) begin
               state_d  = ST_REQ;
               intr_d   = 1'b1;
               int_id_d = prio_id_c;
            end
         end
         ST_REQ: begin
            if (int_taken) begin
               state_d = ST_SERVICE;
               intr_d  = 1'b0;
            end else if (!mie || !mask_q[int_id_q]) begin
               state_d = ST_IDLE;
               intr_d  = 1'b0;
            end
         end
         ST_SERVICE: begin
            intr_d = 1'b0;
            if (mret_exec) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            intr_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         intr_q   <= 1'b0;
         int_id_q <= '0;
         mask_q   <= '0;
      end else begin
         state_q  <= state_d;
         intr_q   <= intr_d;
         int_id_q <= int_id_d;
         mask_q   <= mask_d;
      end
   end

   assign intr   = intr_q;
   assign int_id = int_id_q;
   assign mask   = mask_q;

endmodule
